audio_codec_i2s: RTL and testbench
==================================

// Module: audio_codec_i2s
// PURPOSE
//  I2S master serializer/deserializer for a WM8731-class codec (16-bit, I2S mode, codec as slave).
//  Generates BCLK and LRCK from aud_clk, shifts DAC words out and ADC words in.
//  Sits directly upstream/downstream of the channel master on the audio clock: drives its
//  sample_end/sample_req strobes and audio_input_l/r, and consumes its audio_output_l/r.
// PARAMETERS
//  BCLK_DIV  4   aud_clk cycles per BCLK half-period (>=2); 12.288MHz/(2*4*32) = 48kHz frame
//  SLOT      16  BCLK periods per channel slot (fixed at 16 == data width; frame = 2*SLOT bits)
// PORTS
//  aud_clk          in   1   audio clock; sole clock
//  aud_reset        in   1   synchronous, active-high reset
//  enable           in   1   1 = run serial interface; 0 = hold idle (same state as reset)
//  audio_output_l   in   16  left DAC word from channel master
//  audio_output_r   in   16  right DAC word from channel master
//  audio_input_l    out  16  last complete left ADC word
//  audio_input_r    out  16  last complete right ADC word
//  sample_end       out  2   1-cycle pulse: [1] left ADC word valid, [0] right ADC word valid
//  sample_req       out  2   1-cycle pulse: [1] next left DAC word wanted, [0] next right
//  aud_bclk         out  1   bit clock to codec
//  aud_daclrck      out  1   DAC LR clock (0 = left slot)
//  aud_adclrck      out  1   ADC LR clock (identical to aud_daclrck)
//  aud_dacdat       out  1   serial DAC data
//  aud_adcdat       in   1   serial ADC data from codec
// BEHAVIOUR
//  - Reset / enable=0: all outputs 0 except lrck=1; div_cnt=0; bit_cnt=2*SLOT-1; shifters 0.
//    Reset and enable=0 override everything on the same cycle, mid-frame included.
//  - div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1 aud_bclk toggles, div_cnt wraps.
//    rise_stb/fall_stb = internal 1-cycle strobes on the cycle aud_bclk is set 1/0.
//    First rise BCLK_DIV cycles after reset release, first fall 2*BCLK_DIV.
//  - On fall_stb: bit_cnt <= (bit_cnt==2*SLOT-1) ? 0 : bit_cnt+1; lrck <= (new bit_cnt>=SLOT).
//  - DAC (I2S 1-bit delay): slot position p = bit_cnt mod SLOT. At fall_stb entering p=0 the
//    word for that slot is latched and dacdat emits LSB of previous slot's word; entering p=k
//    (k=1..15) dacdat emits bit 16-k (MSB at p=1). Left word = audio_output_l sampled at
//    fall_stb entering bit_cnt=0; right word = audio_output_r sampled entering bit_cnt=SLOT.
//  - sample_req[1] pulses on fall_stb entering bit_cnt=2*SLOT-1; sample_req[0] on fall_stb
//    entering SLOT-1. Latch occurs 2*BCLK_DIV (>=4) cycles later, covering the master's
//    1-cycle registered response. Never both bits in one cycle.
//  - ADC: aud_adcdat registered once per aud_clk; registered value captured at rise_stb.
//    Rise in p=k (k=1..15) captures bit 16-k; rise in p=0 captures LSB of previous slot.
//  - Left word complete at rise_stb with bit_cnt=SLOT: audio_input_l updated and
//    sample_end[1]=1 on the next cycle (1 cycle). Right: rise_stb with bit_cnt=0 ->
//    audio_input_r, sample_end[0]. audio_input_* hold between updates.
//  - First frame after reset outputs zero DAC words (shifters 0); first sample_end appears
//    only after a full slot has been captured (no partial word ever reported).
//  - aud_adclrck and aud_daclrck are driven by the same register value every cycle.
// TESTING
//  1 BCLK_DIV=4: reset release -> bclk period 8 cycles, lrck toggles every 128, frame 256.
//  2 Pulse spacing: sample_req[1] then sample_req[0] 128 cycles apart, each 1 cycle wide;
//    sample_end[1] occurs 1 cycle after rise in bit_cnt=16.
//  3 Loopback dacdat->adcdat, output_l=16'hA5C3, output_r=16'h3C5A held -> audio_input_l
//    =A5C3, audio_input_r=3C5A from 2nd frame on; never partial words.
//  4 Master model updates audio_output_l 1 cycle after sample_req[1] with 16'h8001 ->
//    dacdat shows 1,0..0,1 MSB-first starting bit_cnt=1, previous right LSB at bit_cnt=0.
//  5 enable=0 at bit_cnt=7 -> next cycle bclk=0, lrck=1, dacdat=0, no strobes;
//    re-enable -> timing identical to case 1.
//  6 aud_reset mid-right-slot -> idle next cycle, audio_input_l/r=0, no spurious sample_end.

Source files
------------

// File: rtl/audio_codec_i2s_if.sv
// rtl/audio_codec_i2s_if.sv - channel-master and codec pin bundle for the I2S serializer
interface audio_codec_i2s_if;
  logic        enable;
  logic [15:0] audio_output_l;
  logic [15:0] audio_output_r;
  logic [15:0] audio_input_l;
  logic [15:0] audio_input_r;
  logic [1:0]  sample_end;
  logic [1:0]  sample_req;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_adclrck;
  logic        aud_dacdat;
  logic        aud_adcdat;

  modport master (
    input  enable, audio_output_l, audio_output_r, aud_adcdat,
    output audio_input_l, audio_input_r, sample_end, sample_req,
           aud_bclk, aud_daclrck, aud_adclrck, aud_dacdat
  );

  modport slave (
    output enable, audio_output_l, audio_output_r, aud_adcdat,
    input  audio_input_l, audio_input_r, sample_end, sample_req,
           aud_bclk, aud_daclrck, aud_adclrck, aud_dacdat
  );
endinterface

// File: rtl/audio_codec_i2s.sv
// rtl/audio_codec_i2s.sv - I2S master: BCLK/LRCK generation, 16-bit DAC shift-out, ADC shift-in
module audio_codec_i2s #(
  parameter int BCLK_DIV = 4,
  parameter int SLOT     = 16
) (
  input  logic               aud_clk,
  input  logic               aud_reset,
  audio_codec_i2s_if.master  bus
);
  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT);
  localparam int PW = $clog2(SLOT);
  localparam logic [DW-1:0] DIV_LAST   = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] SLOT_LAST  = BW'(SLOT - 1);
  localparam logic [BW-1:0] SLOT_FIRST = BW'(SLOT);

  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            bclk_q, bclk_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            lrck_q, lrck_d;
  logic [SLOT-1:0] dac_shift_q, dac_shift_d;
  logic            dacdat_q, dacdat_d;
  logic            adc_reg_q, adc_reg_d;
  logic [SLOT-1:0] adc_shift_q, adc_shift_d;
  logic            full_q, full_d;
  logic [SLOT-1:0] input_l_q, input_l_d;
  logic [SLOT-1:0] input_r_q, input_r_d;
  logic [1:0]      sample_end_q, sample_end_d;
  logic [1:0]      sample_req_q, sample_req_d;

  logic            idle;
  logic            tick;
  logic            rise_stb;
  logic            fall_stb;
  logic [BW-1:0]   bit_nxt;
  logic [PW-1:0]   pos_nxt;
  logic [PW-1:0]   pos_cur;
  logic [PW-1:0]   dac_idx;
  logic [SLOT-1:0] adc_word;

  always_comb begin
    idle     = aud_reset | ~bus.enable;
    tick     = (div_cnt_q == DIV_LAST);
    rise_stb = tick & ~bclk_q;
    fall_stb = tick & bclk_q;
    bit_nxt  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    pos_nxt  = bit_nxt[PW-1:0];
    pos_cur  = bit_cnt_q[PW-1:0];
    // slot position k emits bit SLOT-k, i.e. the two's complement of k within the slot
    dac_idx  = ~pos_nxt + 1'b1;
    adc_word = {adc_shift_q[SLOT-2:0], adc_reg_q};

    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    bclk_d       = bclk_q ^ tick;
    bit_cnt_d    = bit_cnt_q;
    lrck_d       = lrck_q;
    dac_shift_d  = dac_shift_q;
    dacdat_d     = dacdat_q;
    adc_reg_d    = bus.aud_adcdat;
    adc_shift_d  = adc_shift_q;
    full_d       = full_q;
    input_l_d    = input_l_q;
    input_r_d    = input_r_q;
    sample_end_d = '0;
    sample_req_d = '0;

    if (fall_stb) begin
      bit_cnt_d    = bit_nxt;
      lrck_d       = (bit_nxt >= SLOT_FIRST);
      sample_req_d = {bit_nxt == BIT_LAST, bit_nxt == SLOT_LAST};
      if (pos_nxt == '0) begin
        dacdat_d    = dac_shift_q[0];
        dac_shift_d = bit_nxt[PW] ? bus.audio_output_r : bus.audio_output_l;
      end else begin
        dacdat_d = dac_shift_q[dac_idx];
      end
    end

    if (rise_stb) begin
      adc_shift_d = adc_word;
      // only a slot whose MSB was captured after reset may be reported
      if (pos_cur == PW'(1)) begin
        full_d = 1'b1;
      end
      if (full_q && pos_cur == '0) begin
        if (bit_cnt_q[PW]) begin
          input_l_d       = adc_word;
          sample_end_d[1] = 1'b1;
        end else begin
          input_r_d       = adc_word;
          sample_end_d[0] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aud_clk) begin
    if (idle) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= BIT_LAST;
      lrck_q       <= 1'b1;
      dac_shift_q  <= '0;
      dacdat_q     <= 1'b0;
      adc_reg_q    <= 1'b0;
      adc_shift_q  <= '0;
      full_q       <= 1'b0;
      input_l_q    <= '0;
      input_r_q    <= '0;
      sample_end_q <= '0;
      sample_req_q <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrck_q       <= lrck_d;
      dac_shift_q  <= dac_shift_d;
      dacdat_q     <= dacdat_d;
      adc_reg_q    <= adc_reg_d;
      adc_shift_q  <= adc_shift_d;
      full_q       <= full_d;
      input_l_q    <= input_l_d;
      input_r_q    <= input_r_d;
      sample_end_q <= sample_end_d;
      sample_req_q <= sample_req_d;
    end
  end

  assign bus.aud_bclk      = bclk_q;
  assign bus.aud_daclrck   = lrck_q;
  assign bus.aud_adclrck   = lrck_q;
  assign bus.aud_dacdat    = dacdat_q;
  assign bus.audio_input_l = input_l_q;
  assign bus.audio_input_r = input_r_q;
  assign bus.sample_end    = sample_end_q;
  assign bus.sample_req    = sample_req_q;
endmodule

// File: tb/tb_audio_codec_i2s.sv
// tb/tb_audio_codec_i2s.sv - bench for audio_codec_i2s: time-indexed reference model, vector table, corner sequences
module tb_audio_codec_i2s;
  localparam int BD    = 4;
  localparam int PER   = 2 * BD;
  localparam int FRAME = 32 * PER;

  logic aud_clk = 1'b0;
  logic aud_reset;
  audio_codec_i2s_if bus();

  audio_codec_i2s #(.BCLK_DIV(BD), .SLOT(16)) dut (
    .aud_clk   (aud_clk),
    .aud_reset (aud_reset),
    .bus       (bus)
  );

  always #5 aud_clk = ~aud_clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int errors = 0;

  // reference model: everything derives from k, the count of running cycles since idle
  int          k;
  bit          hist[int];
  bit          rise_bit[int];
  logic [15:0] slot_word[int];
  logic [15:0] m_in_l, m_in_r;
  logic [1:0]  m_se, m_sr;
  logic        m_bclk, m_lrck, m_dac;
  bit          loopback;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h k=%0d t=%0t", name, act, exp, k, $time);
    end
  endtask

  task automatic model_edge();
    int f, bitc, p, s;
    logic [15:0] w;
    m_se = '0;
    m_sr = '0;
    if (aud_reset || !bus.enable) begin
      k = 0;
      hist.delete();
      rise_bit.delete();
      slot_word.delete();
      m_in_l = '0; m_in_r = '0;
      m_dac = 1'b0; m_bclk = 1'b0; m_lrck = 1'b1;
      return;
    end
    k++;
    hist[k] = bus.aud_adcdat;
    f      = k / PER;
    bitc   = (f + 31) % 32;
    m_bclk = ((k / BD) % 2) == 1;
    m_lrck = bitc >= 16;
    if (k % PER == 0) begin
      p = bitc % 16;
      s = (f - 1) / 16;
      if (p == 0) begin
        slot_word[s] = (s % 2 == 0) ? bus.audio_output_l : bus.audio_output_r;
        if (s > 0) begin
          w = slot_word[s-1];
          m_dac = w[0];
        end else begin
          m_dac = 1'b0;
        end
      end else begin
        w = slot_word[s];
        m_dac = w[16-p];
      end
      m_sr = {bitc == 31, bitc == 15};
    end
    if (k % PER == BD) begin
      rise_bit[f] = hist[k-1];
      if (f >= 17 && bitc % 16 == 0) begin
        w = '0;
        for (int j = 0; j < 16; j++) w[15-j] = rise_bit[f-15+j];
        if (bitc == 16) begin
          m_in_l = w; m_se[1] = 1'b1;
        end else begin
          m_in_r = w; m_se[0] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge aud_clk);
    model_edge();
    @(negedge aud_clk);
    chk("bclk", bus.aud_bclk, m_bclk);
    chk("daclrck", bus.aud_daclrck, m_lrck);
    chk("adclrck", bus.aud_adclrck, m_lrck);
    chk("dacdat", bus.aud_dacdat, m_dac);
    chk("sample_req", bus.sample_req, m_sr);
    chk("sample_end", bus.sample_end, m_se);
    chk("input_l", bus.audio_input_l, m_in_l);
    chk("input_r", bus.audio_input_r, m_in_r);
    bus.aud_adcdat = loopback ? bus.aud_dacdat : 1'($urandom_range(1));
  endtask

  int rise_at, lr_at, lr_hi_at, sr1_at, sr0_at, se1_at, spurious;
  bit pend_l, pend_r;

  initial begin
    vecs[0] = '{16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A};
    vecs[1] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[3] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};

    aud_reset = 1'b1;
    loopback  = 1'b0;
    bus.enable = 1'b1;
    bus.audio_output_l = '0;
    bus.audio_output_r = '0;
    bus.aud_adcdat = 1'b0;
    k = 0;

    step(); step();
    chk("rst_bclk", bus.aud_bclk, 1'b0);
    chk("rst_lrck", bus.aud_daclrck, 1'b1);
    chk("rst_in_l", bus.audio_input_l, 16'h0000);
    chk("rst_se", bus.sample_end, 2'b00);

    // timing after reset release
    aud_reset = 1'b0;
    rise_at = -1; lr_at = -1; lr_hi_at = -1; sr1_at = -1; sr0_at = -1; se1_at = -1;
    for (int n = 1; n <= 400; n++) begin
      step();
      if (rise_at < 0 && bus.aud_bclk) rise_at = n;
      if (lr_at < 0 && !bus.aud_daclrck) lr_at = n;
      if (lr_at > 0 && lr_hi_at < 0 && bus.aud_daclrck) lr_hi_at = n;
      if (sr1_at < 0 && bus.sample_req[1]) sr1_at = n;
      if (sr1_at > 0 && sr0_at < 0 && bus.sample_req[0]) sr0_at = n;
      if (se1_at < 0 && bus.sample_end[1]) se1_at = n;
    end
    chk("first_rise", rise_at, BD);
    chk("first_fall_lrck", lr_at, PER);
    chk("lrck_half_frame", lr_hi_at - lr_at, 16 * PER);
    chk("first_req_l", sr1_at, 32 * PER);
    chk("req_spacing", sr0_at - sr1_at, 16 * PER);
    chk("first_end_l", se1_at, BD + 17 * PER);

    // loopback vector table
    for (int i = 0; i < 4; i++) begin
      aud_reset = 1'b1;
      loopback  = 1'b1;
      bus.audio_output_l = vecs[i].l;
      bus.audio_output_r = vecs[i].r;
      step();
      aud_reset = 1'b0;
      repeat (3 * FRAME) step();
      chk($sformatf("vec%0d_in_l", i), bus.audio_input_l, vecs[i].exp_l);
      chk($sformatf("vec%0d_in_r", i), bus.audio_input_r, vecs[i].exp_r);
    end

    // enable drop at bit_cnt 7, then restart
    aud_reset = 1'b1; loopback = 1'b0; step();
    aud_reset = 1'b0;
    repeat (8 * PER + 3) step();
    bus.enable = 1'b0;
    step();
    chk("dis_bclk", bus.aud_bclk, 1'b0);
    chk("dis_lrck", bus.aud_daclrck, 1'b1);
    chk("dis_dac", bus.aud_dacdat, 1'b0);
    chk("dis_strobes", {bus.sample_req, bus.sample_end}, 4'h0);
    repeat (5) step();
    bus.enable = 1'b1;
    rise_at = -1;
    for (int n = 1; n <= 3 * BD; n++) begin
      step();
      if (rise_at < 0 && bus.aud_bclk) rise_at = n;
    end
    chk("reen_first_rise", rise_at, BD);

    // reset in the right slot after words have been received
    aud_reset = 1'b1; loopback = 1'b1;
    bus.audio_output_l = 16'hA5C3; bus.audio_output_r = 16'h3C5A;
    step();
    aud_reset = 1'b0;
    repeat (2 * FRAME + 150) step();
    chk("pre_rst_in_l", bus.audio_input_l, 16'hA5C3);
    aud_reset = 1'b1;
    step();
    chk("mid_rst_in_l", bus.audio_input_l, 16'h0000);
    chk("mid_rst_in_r", bus.audio_input_r, 16'h0000);
    chk("mid_rst_bclk", bus.aud_bclk, 1'b0);
    aud_reset = 1'b0;
    spurious = 0;
    for (int n = 1; n < BD + 17 * PER; n++) begin
      step();
      if (bus.sample_end != 2'b00) spurious++;
    end
    chk("no_spurious_end", spurious, 0);

    // random ADC data with a master answering sample_req one cycle later
    aud_reset = 1'b1; loopback = 1'b0;
    step();
    aud_reset = 1'b0;
    pend_l = 1'b0; pend_r = 1'b0;
    for (int n = 0; n < 4 * FRAME; n++) begin
      if (pend_l) bus.audio_output_l = 16'($urandom);
      if (pend_r) bus.audio_output_r = 16'($urandom);
      pend_l = 1'b0; pend_r = 1'b0;
      step();
      if (bus.sample_req[1]) pend_l = 1'b1;
      if (bus.sample_req[0]) pend_r = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
